// File: rtl/dual_slope_adc_ctrl.sv
// Multi-channel dual-slope conversion controller: integrate a live sample for T_INT
// cycles, then count reference-sized steps back down. Supports single/scan modes.
module dual_slope_adc_ctrl #(
   parameter int IN_W  = 8,
   parameter int RES_W = 8,
   parameter int N_CH  = 4,
   parameter int CH_W  = 2,
   parameter int T_INT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 scan_en,
   input  logic [CH_W-1:0]      ch_sel,
   input  logic [N_CH*IN_W-1:0] ain,
   input  logic [IN_W-1:0]      ref_level,
   output logic                 busy,
   output logic                 done,
   output logic [RES_W-1:0]     result,
   output logic [CH_W-1:0]      result_ch,
   output logic                 ovf,
   output logic [2:0]           dbg_state
);

   localparam int ICNT_W = $clog2(T_INT + 1);
   localparam int ACC_W  = IN_W + ICNT_W;

   // Handshake: start is a request taken only while idle; busy acknowledges it and stays
   // high until the controller is idle again; done is a one-cycle strobe that qualifies
   // result, result_ch and ovf, which are then held until the next done.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AZ    = 3'd1,
      S_INT   = 3'd2,
      S_DEINT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state;
   logic                scan_q;
   logic                ovf_q;
   logic [CH_W-1:0]     ch;
   logic [IN_W-1:0]     ref_q;
   logic [ACC_W-1:0]    acc;
   logic [RES_W-1:0]    cnt;
   logic [ICNT_W-1:0]   int_cnt;

   logic [IN_W-1:0]     sample;
   logic [ACC_W-1:0]    ref_ext;
   logic [ACC_W-1:0]    acc_sub;
   logic [RES_W-1:0]    cnt_inc;
   logic                last_ch;

   // Channels beyond N_CH have no sample and read as zero.
   always_comb begin
      sample = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch == CH_W'(i)) sample = ain[i*IN_W +: IN_W];
      end
   end

   assign ref_ext   = ACC_W'(ref_q);
   assign acc_sub   = acc - ref_ext;
   assign cnt_inc   = cnt + RES_W'(1);
   assign last_ch   = (ch == CH_W'(N_CH - 1));
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         scan_q    <= 1'b0;
         ovf_q     <= 1'b0;
         ch        <= '0;
         ref_q     <= '0;
         acc       <= '0;
         cnt       <= '0;
         int_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         result_ch <= '0;
         ovf       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  scan_q <= scan_en;
                  ch     <= scan_en ? '0 : ch_sel;
                  ref_q  <= ref_level;
                  busy   <= 1'b1;
                  state  <= S_AZ;
               end
            end
            S_AZ: begin
               acc     <= '0;
               cnt     <= '0;
               int_cnt <= '0;
               ovf_q   <= 1'b0;
               state   <= S_INT;
            end
            S_INT: begin
               acc     <= acc + ACC_W'(sample);
               int_cnt <= int_cnt + ICNT_W'(1);
               if (int_cnt == ICNT_W'(T_INT - 1)) state <= S_DEINT;
            end
            S_DEINT: begin
               if (ref_q == '0) begin
                  cnt   <= '1;
                  ovf_q <= 1'b1;
                  state <= S_DONE;
               end else if (acc >= ref_ext) begin
                  acc <= acc_sub;
                  cnt <= cnt_inc;
                  // Counter is about to reach full scale with at least one more step left.
                  if ((&cnt_inc) && (acc_sub >= ref_ext)) begin
                     ovf_q <= 1'b1;
                     state <= S_DONE;
                  end
               end else begin
                  ovf_q <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done      <= 1'b1;
               result    <= cnt;
               result_ch <= ch;
               ovf       <= ovf_q;
               if (!scan_q || last_ch) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  ch    <= ch + CH_W'(1);
                  state <= S_AZ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dual_slope_adc_ctrl.sv
// Bench for dual_slope_adc_ctrl: a timeline/arithmetic model checked every cycle,
// plus directed scenarios with hand-computed results and latencies.
module tb_dual_slope_adc_ctrl;

   localparam int IN_W  = 8;
   localparam int RES_W = 8;
   localparam int N_CH  = 4;
   localparam int CH_W  = 2;
   localparam int T_INT = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 scan_en = 1'b0;
   logic [CH_W-1:0]      ch_sel = '0;
   logic [N_CH*IN_W-1:0] ain = '0;
   logic [IN_W-1:0]      ref_level = '0;
   logic                 busy;
   logic                 done;
   logic [RES_W-1:0]     result;
   logic [CH_W-1:0]      result_ch;
   logic                 ovf;
   logic [2:0]           dbg_state;

   dual_slope_adc_ctrl #(
      .IN_W(IN_W), .RES_W(RES_W), .N_CH(N_CH), .CH_W(CH_W), .T_INT(T_INT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .scan_en(scan_en), .ch_sel(ch_sel),
      .ain(ain), .ref_level(ref_level), .busy(busy), .done(done), .result(result),
      .result_ch(result_ch), .ovf(ovf), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks each conversion as a timeline counted from the accepting edge:
   // edge 1 is auto-zero, edges 2..T_INT+1 add the live sample, then the
   // de-integrate length follows from floor(sum/ref) and done closes it.
   bit m_busy, m_done, m_scan, m_ovf;
   int m_result, m_rch, m_cur, m_ref, m_t, m_sum, m_done_at, m_r, m_o;

   function automatic int sample_of(input int c);
      if (c >= N_CH) return 0;
      return int'(ain[c*IN_W +: IN_W]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_ovf = 0; m_result = 0; m_rch = 0;
         m_t = 0; m_sum = 0; m_done_at = 1 << 30;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_scan = scan_en; m_cur = scan_en ? 0 : int'(ch_sel);
               m_ref = int'(ref_level); m_t = 0; m_sum = 0; m_done_at = 1 << 30;
            end
         end else begin
            m_t++;
            if (m_t >= 2 && m_t <= T_INT + 1) m_sum += sample_of(m_cur);
            if (m_t == T_INT + 1) begin
               int deint;
               if (m_ref == 0) begin
                  m_r = 255; m_o = 1; deint = 1;
               end else if (m_sum / m_ref > 255) begin
                  m_r = 255; m_o = 1; deint = 255;
               end else begin
                  m_r = m_sum / m_ref; m_o = 0; deint = m_r + 1;
               end
               m_done_at = T_INT + 2 + deint;
            end
            if (m_t == m_done_at) begin
               m_done = 1; m_result = m_r; m_rch = m_cur; m_ovf = m_o[0];
               if (!m_scan || m_cur == N_CH - 1) m_busy = 0;
               else begin
                  m_cur++; m_t = 0; m_sum = 0; m_done_at = 1 << 30;
               end
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("result", result, m_result);
         chk("result_ch", result_ch, m_rch);
         chk("ovf", ovf, m_ovf);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_ain(input int c, input int v);
      ain[c*IN_W +: IN_W] = IN_W'(v);
   endtask

   task automatic do_start(input int c, input bit scan, input int rv, output int e0);
      @(negedge clk);
      ch_sel = CH_W'(c); scan_en = scan; ref_level = IN_W'(rv); start = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string name, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         vectors++; miscompares++;
         $display("FAIL %s: no done within %0d cycles", name, bound);
      end
   endtask

   initial begin
      #2_000_000;
      miscompares++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int e0, t, t2, ndone;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_result_ch", result_ch, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // 1 single conversion: 16*10/16 = 10, latency 16+10+3
      set_ain(2, 10);
      do_start(2, 0, 16, e0);
      wait_done(100, "t1_done", t);
      chk("t1_result", result, 10);
      chk("t1_ch", result_ch, 2);
      chk("t1_ovf", ovf, 0);
      chk("t1_latency", t - e0, 29);
      chk("t1_busy_low", busy, 0);

      // 2 saturation: 16*255/1 >= 256 -> 255 with ovf, DEINT stops after 255 steps
      set_ain(0, 255);
      do_start(0, 0, 1, e0);
      wait_done(400, "t2_done", t);
      chk("t2_result", result, 255);
      chk("t2_ovf", ovf, 1);
      chk("t2_latency", t - e0, 16 + 2 + 255);
      @(posedge clk); #1;
      chk("t2_single_pulse", done, 0);
      do_start(0, 0, 0, e0);
      wait_done(100, "t2z_done", t);
      chk("t2z_result", result, 255);
      chk("t2z_ovf", ovf, 1);
      chk("t2z_latency", t - e0, 19);

      // 3 scan: {48,0,32,16} with ref 16 -> 16,32,0,48
      set_ain(0, 16); set_ain(1, 32); set_ain(2, 0); set_ain(3, 48);
      do_start(3, 1, 16, e0);
      for (int k = 0; k < 4; k++) begin
         int exp_r[4] = '{16, 32, 0, 48};
         wait_done(200, "t3_done", t);
         chk("t3_ch", result_ch, k);
         chk("t3_result", result, exp_r[k]);
         chk("t3_busy", busy, (k == 3) ? 0 : 1);
      end

      // 4 protocol: start during INT and DEINT ignored; 16*20/10 = 32
      set_ain(1, 20); set_ain(3, 99);
      do_start(1, 0, 10, e0);
      repeat (4) @(negedge clk);
      ch_sel = 2'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (18) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0; ch_sel = 2'd1;
      wait_done(200, "t4_done", t);
      chk("t4_result", result, 32);
      chk("t4_ch", result_ch, 1);
      chk("t4_latency", t - e0, 51);
      ndone = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      chk("t4_extra_done", ndone, 0);
      // back-to-back with start held high
      @(negedge clk);
      ch_sel = 2'd1; scan_en = 1'b0; ref_level = 8'd10; start = 1'b1;
      @(posedge clk); #1;
      e0 = cyc;
      wait_done(200, "t4b_done", t);
      chk("t4b_busy_low", busy, 0);
      @(posedge clk); #1;
      chk("t4b_reaccept", busy, 1);
      @(negedge clk); start = 1'b0;
      wait_done(200, "t4b2_done", t2);
      chk("t4b2_result", result, 32);
      chk("t4b2_latency", t2 - t, 52);

      // 5 reset mid-INT, then a clean conversion
      set_ain(2, 10);
      do_start(2, 0, 16, e0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_result", result, 0);
      chk("t5_ch", result_ch, 0);
      chk("t5_ovf", ovf, 0);
      chk("t5_state", dbg_state, 0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      chk("t5_no_done", ndone, 0);
      do_start(2, 0, 16, e0);
      wait_done(100, "t5b_done", t);
      chk("t5b_result", result, 10);
      chk("t5b_latency", t - e0, 29);

      // 6 ramp on ch1: 0..15 during INT, 200 outside -> sum 120, /8 = 15
      set_ain(1, 200);
      do_start(1, 0, 8, e0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         set_ain(1, k);
      end
      @(negedge clk);
      set_ain(1, 200);
      wait_done(100, "t6_done", t);
      chk("t6_result", result, 15);
      chk("t6_ovf", ovf, 0);
      chk("t6_latency", t - e0, 34);

      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
